// File: rtl/oram_requester.sv
// Host-side requester for an ORAM: queues read/write commands in a FIFO and issues them
// one at a time, with a bounded wait and a timeout error response.
module oram_requester #(
  parameter int unsigned D       = 4,
  parameter int unsigned A       = 1,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_rw,
  input  logic [D-1:0]     cmd_addr,
  input  logic [8*A-1:0]   cmd_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_rw,
  output logic [8*A-1:0]   rsp_rdata,
  output logic             rsp_err,
  output logic [D-1:0]     rw_block_number,
  output logic [8*A-1:0]   w_value,
  output logic             rw_indicator,
  output logic             input_ready,
  input  logic [8*A-1:0]   r_value,
  input  logic             output_ready,
  output logic [15:0]      ops_done,
  output logic [7:0]       timeout_count
);
  localparam int unsigned W  = 8 * A;
  localparam int unsigned EW = 1 + D + W;
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  // Command FIFO: entries packed as {rw, addr, wdata}
  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          push, pop, full, empty;
  logic [EW-1:0] head;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign cmd_ready = ~full;
  assign push      = cmd_valid & ~full;
  assign head      = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_rw, cmd_addr, cmd_wdata};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  state_e        state_q, state_d;
  logic [TW-1:0] wait_cnt_q, wait_cnt_d;
  logic          input_ready_q, input_ready_d;
  logic [D-1:0]  rw_block_number_q, rw_block_number_d;
  logic [W-1:0]  w_value_q, w_value_d;
  logic          rw_indicator_q, rw_indicator_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_rw_q, rsp_rw_d;
  logic [W-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;
  logic [15:0]   ops_done_q, ops_done_d;
  logic [7:0]    timeout_count_q, timeout_count_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= StIdle;
      wait_cnt_q        <= '0;
      input_ready_q     <= 1'b0;
      rw_block_number_q <= '0;
      w_value_q         <= '0;
      rw_indicator_q    <= 1'b0;
      rsp_valid_q       <= 1'b0;
      rsp_rw_q          <= 1'b0;
      rsp_rdata_q       <= '0;
      rsp_err_q         <= 1'b0;
      ops_done_q        <= '0;
      timeout_count_q   <= '0;
    end else begin
      state_q           <= state_d;
      wait_cnt_q        <= wait_cnt_d;
      input_ready_q     <= input_ready_d;
      rw_block_number_q <= rw_block_number_d;
      w_value_q         <= w_value_d;
      rw_indicator_q    <= rw_indicator_d;
      rsp_valid_q       <= rsp_valid_d;
      rsp_rw_q          <= rsp_rw_d;
      rsp_rdata_q       <= rsp_rdata_d;
      rsp_err_q         <= rsp_err_d;
      ops_done_q        <= ops_done_d;
      timeout_count_q   <= timeout_count_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    wait_cnt_d        = wait_cnt_q;
    pop               = 1'b0;
    input_ready_d     = 1'b0;
    rw_block_number_d = rw_block_number_q;
    w_value_d         = w_value_q;
    rw_indicator_d    = rw_indicator_q;
    rsp_valid_d       = rsp_valid_q;
    rsp_rw_d          = rsp_rw_q;
    rsp_rdata_d       = rsp_rdata_q;
    rsp_err_d         = rsp_err_q;
    ops_done_d        = ops_done_q;
    timeout_count_d   = timeout_count_q;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop               = 1'b1;
          rw_indicator_d    = head[EW-1];
          rw_block_number_d = head[W +: D];
          w_value_d         = head[W-1:0];
          input_ready_d     = 1'b1;
          state_d           = StIssue;
        end
      end
      StIssue: begin
        wait_cnt_d = '0;
        state_d    = StWait;
      end
      StWait: begin
        // A response on the expiry cycle takes priority over the timeout
        if (output_ready) begin
          rsp_valid_d = 1'b1;
          rsp_rw_d    = rw_indicator_q;
          rsp_rdata_d = rw_indicator_q ? '0 : r_value;
          rsp_err_d   = 1'b0;
          state_d     = StResp;
        end else if (wait_cnt_q == TW'(TIMEOUT - 1)) begin
          rsp_valid_d = 1'b1;
          rsp_rw_d    = rw_indicator_q;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          state_d     = StResp;
        end else begin
          wait_cnt_d = wait_cnt_q + TW'(1);
        end
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
          if (ops_done_q != 16'hFFFF) ops_done_d = ops_done_q + 16'd1;
          if (rsp_err_q && (timeout_count_q != 8'hFF)) timeout_count_d = timeout_count_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign input_ready     = input_ready_q;
  assign rw_block_number = rw_block_number_q;
  assign w_value         = w_value_q;
  assign rw_indicator    = rw_indicator_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_rw          = rsp_rw_q;
  assign rsp_rdata       = rsp_rdata_q;
  assign rsp_err         = rsp_err_q;
  assign ops_done        = ops_done_q;
  assign timeout_count   = timeout_count_q;

endmodule
